multitimer: RTL and testbench

MULTITIMER -- requirements
Module: multitimer

---
 rtl/multitimer_pkg.sv | 32 +++
 rtl/timer_chan.sv | 123 ++++++++++++
 rtl/multitimer.sv | 77 +++++++
 tb/tb_multitimer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/multitimer_pkg.sv
// Shared constants for the multitimer: register offsets within a channel,
// CTRL bit positions, maximum counter width and a byte-select helper.
package multitimer_pkg;

  localparam int unsigned MAX_WIDTH = 24;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_RLD_H   = 3'd1;
  localparam logic [2:0] OFF_RLD_M   = 3'd2;
  localparam logic [2:0] OFF_RLD_L   = 3'd3;
  localparam logic [2:0] OFF_CNT_H   = 3'd4;
  localparam logic [2:0] OFF_CNT_M   = 3'd5;
  localparam logic [2:0] OFF_CNT_L   = 3'd6;
  localparam logic [2:0] OFF_SUMMARY = 3'd7;

  localparam int unsigned CTRL_IRQ     = 7;
  localparam int unsigned CTRL_IEN     = 6;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_RUN     = 0;

  // Byte 2 = [23:16], byte 1 = [15:8], byte 0 = [7:0].
  function automatic logic [7:0] byte_of(input logic [MAX_WIDTH-1:0] v,
                                         input logic [1:0] sel);
    case (sel)
      2'd2:    byte_of = v[23:16];
      2'd1:    byte_of = v[15:8];
      2'd0:    byte_of = v[7:0];
      default: byte_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: CTRL flags, reload register, down-counter and the
// count snapshot used for coherent multi-byte reads.
module timer_chan
  import multitimer_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [2:0] off,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       flag,
  output logic       irq
);

  logic             flag_q, flag_d;
  logic             ien_q, ien_d;
  logic             oneshot_q, oneshot_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] snap_q, snap_d;

  logic                 ctrl_wr;
  logic                 start;
  logic [MAX_WIDTH-1:0] rld_wr;
  logic [MAX_WIDTH-1:0] rld_rd;
  logic [MAX_WIDTH-1:0] cnt_rd;
  logic [MAX_WIDTH-1:0] snap_rd;

  assign ctrl_wr = wr_en && (off == OFF_CTRL);
  assign start   = ctrl_wr && wdata[CTRL_RUN] && !run_q;

  // Next-state: register writes, start/stop, countdown and expiry handling.
  always_comb begin
    flag_d    = flag_q;
    ien_d     = ien_q;
    oneshot_d = oneshot_q;
    run_d     = run_q;
    count_d   = count_q;
    snap_d    = snap_q;
    rld_wr    = MAX_WIDTH'(reload_q);

    if (ctrl_wr) begin
      ien_d     = wdata[CTRL_IEN];
      oneshot_d = wdata[CTRL_ONESHOT];
      run_d     = wdata[CTRL_RUN];
      if (wdata[CTRL_IRQ]) flag_d = 1'b0;
    end

    if (wr_en) begin
      case (off)
        OFF_RLD_H: rld_wr[23:16] = wdata;
        OFF_RLD_M: rld_wr[15:8]  = wdata;
        OFF_RLD_L: rld_wr[7:0]   = wdata;
        default:   ;
      endcase
    end
    reload_d = rld_wr[WIDTH-1:0];

    if (rd_en && (off == OFF_CNT_H)) snap_d = count_q;

    // A stop write suppresses the tick in its own cycle, so COUNT freezes
    // at its current value; an expiry later in this block overrides a
    // same-cycle flag clear.
    if (start) begin
      count_d = reload_q;
    end else if (run_q && run_d) begin
      if (count_q == '0) begin
        flag_d = 1'b1;
        if (oneshot_q) run_d = 1'b0;
        else           count_d = reload_q;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Channel state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      ien_q     <= 1'b0;
      oneshot_q <= 1'b0;
      run_q     <= 1'b0;
      reload_q  <= '0;
      count_q   <= '0;
      snap_q    <= '0;
    end else begin
      flag_q    <= flag_d;
      ien_q     <= ien_d;
      oneshot_q <= oneshot_d;
      run_q     <= run_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
    end
  end

  // Read data for this channel's offsets; COUNT high byte is live, lower bytes come from the snapshot.
  always_comb begin
    rld_rd  = MAX_WIDTH'(reload_q);
    cnt_rd  = MAX_WIDTH'(count_q);
    snap_rd = MAX_WIDTH'(snap_q);
    case (off)
      OFF_CTRL:  rdata = {flag_q, ien_q, 4'b0000, oneshot_q, run_q};
      OFF_RLD_H: rdata = byte_of(rld_rd, 2'd2);
      OFF_RLD_M: rdata = byte_of(rld_rd, 2'd1);
      OFF_RLD_L: rdata = byte_of(rld_rd, 2'd0);
      OFF_CNT_H: rdata = byte_of(cnt_rd, 2'd2);
      OFF_CNT_M: rdata = byte_of(snap_rd, 2'd1);
      OFF_CNT_L: rdata = byte_of(snap_rd, 2'd0);
      default:   rdata = '0;
    endcase
  end

  assign flag = flag_q;
  assign irq  = flag_q && ien_q;

endmodule

// File: rtl/multitimer.sv
// Multi-channel down-counting timer with byte-wide register interface,
// per-channel interrupt flags and a combined interrupt output.
module multitimer
  import multitimer_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq
);

  logic [1:0]          ch;
  logic [2:0]          off;
  logic [CHANNELS-1:0] flags;
  logic [CHANNELS-1:0] irqs;
  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] rd_sel;
  logic [7:0]          chan_rdata [CHANNELS];
  logic [7:0]          summary;
  logic [7:0]          rd_data;
  logic [7:0]          do_q, do_d;

  assign ch  = AD[4:3];
  assign off = AD[2:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr_sel[i] = cs && !rw && (ch == 2'(i));
    assign rd_sel[i] = cs &&  rw && (ch == 2'(i));

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_sel[i]),
      .rd_en (rd_sel[i]),
      .off   (off),
      .wdata (DI),
      .rdata (chan_rdata[i]),
      .flag  (flags[i]),
      .irq   (irqs[i])
    );
  end

  // SUMMARY byte: one IRQ flag per implemented channel, upper bits zero.
  always_comb begin
    summary                 = '0;
    summary[CHANNELS-1:0]   = flags;
  end

  // Read mux: unimplemented channels and +7 of channels other than 0 read zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch == 2'(i)) begin
        if (off == OFF_SUMMARY) rd_data = (i == 0) ? summary : '0;
        else                    rd_data = chan_rdata[i];
      end
    end
    do_d = (cs && rw) ? rd_data : do_q;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) do_q <= '0;
    else        do_q <= do_d;
  end

  assign DO  = do_q;
  assign irq = |irqs;

endmodule

// File: tb/tb_multitimer.sv
// Directed self-checking bench for multitimer (CHANNELS=2, WIDTH=24).
module tb_multitimer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;

  int n_total = 0;
  int n_bad   = 0;

  multitimer #(.CHANNELS(2), .WIDTH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .AD    (AD),
    .DI    (DI),
    .DO    (DO),
    .rw    (rw),
    .cs    (cs),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the access lands on the next edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic rdchk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    AD = a; rw = 1'b1; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; rw = 1'b0;
    chk(tag, DO, exp);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; rw = 1'b0; AD = '0; DI = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_do", DO, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state of the whole map, including out-of-range addresses.
    for (int a = 0; a < 16; a++) rdchk(5'(a), 8'h00, $sformatf("init_%0d", a));
    rdchk(5'd16, 8'h00, "oor_16");
    rdchk(5'd31, 8'h00, "oor_31");

    // Writes to unimplemented locations are ignored.
    wr(5'd16, 8'hFF);
    wr(5'd15, 8'hFF);
    rdchk(5'd16, 8'h00, "oor_wr16");
    rdchk(5'd15, 8'h00, "ch1_p7");
    rdchk(5'd0,  8'h00, "ch0_ctrl_untouched");
    rdchk(5'd8,  8'h00, "ch1_ctrl_untouched");

    // Periodic: RELOAD=4 gives irq 5 cycles after start, then every 5.
    wr(5'd1, 8'h00); wr(5'd2, 8'h00); wr(5'd3, 8'h04);
    rdchk(5'd3, 8'h04, "rld_lo");
    @(posedge clk); #1;
    chk("do_hold", DO, 8'h04);
    wr(5'd0, 8'h41);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("per_a%0d", k), irq, (k == 5));
    end
    wr(5'd0, 8'hC1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("per_b%0d", k), irq, (k == 4));
    end
    repeat (7) @(posedge clk);
    #1;
    chk("per_sticky", irq, 1);
    rdchk(5'd0, 8'hC1, "per_ctrl");
    wr(5'd0, 8'h80);
    chk("per_stop_irq", irq, 0);

    // One-shot: RELOAD=2 expires once, RUN clears, COUNT stays zero.
    wr(5'd3, 8'h02);
    wr(5'd0, 8'h43);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("os_%0d", k), irq, (k == 3));
    end
    rdchk(5'd0, 8'hC2, "os_ctrl");
    rdchk(5'd4, 8'h00, "os_cnt_h");
    rdchk(5'd5, 8'h00, "os_cnt_m");
    rdchk(5'd6, 8'h00, "os_cnt_l");
    wr(5'd0, 8'hC2);
    repeat (10) @(posedge clk);
    #1;
    chk("os_quiet", irq, 0);
    rdchk(5'd0, 8'h42, "os_ctrl2");

    // Snapshot across the 0x010000 -> 0x00FFFF carry.
    wr(5'd0, 8'h00);
    wr(5'd1, 8'h01); wr(5'd2, 8'h00); wr(5'd3, 8'hFF);
    wr(5'd0, 8'h01);
    repeat (255) @(posedge clk);
    #1;
    rdchk(5'd4, 8'h01, "snap_h");
    rdchk(5'd5, 8'h00, "snap_m");
    rdchk(5'd6, 8'h00, "snap_l");
    // RELOAD write while running leaves COUNT alone (0x0100FF - 259 = 0xFFFC).
    wr(5'd3, 8'h10);
    rdchk(5'd4, 8'h00, "run_h");
    rdchk(5'd5, 8'hFF, "run_m");
    rdchk(5'd6, 8'hFC, "run_l");
    rdchk(5'd1, 8'h01, "rld2_h");
    rdchk(5'd3, 8'h10, "rld2_l");
    // Stop freezes COUNT at 0xFFF7; restart loads 0x010010.
    wr(5'd0, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    rdchk(5'd4, 8'h00, "frz_h");
    rdchk(5'd5, 8'hFF, "frz_m");
    rdchk(5'd6, 8'hF7, "frz_l");
    wr(5'd0, 8'h01);
    rdchk(5'd4, 8'h01, "rst_h");
    rdchk(5'd5, 8'h00, "rst_m");
    rdchk(5'd6, 8'h10, "rst_l");
    wr(5'd0, 8'h00);

    // RELOAD=0: a clear landing on an expiry cycle leaves the flag set.
    wr(5'd1, 8'h00); wr(5'd3, 8'h00);
    wr(5'd0, 8'h41);
    repeat (2) @(posedge clk);
    #1;
    chk("r0_irq", irq, 1);
    wr(5'd0, 8'hC1);
    rdchk(5'd0, 8'hC1, "r0_setwins");
    wr(5'd0, 8'h80);
    rdchk(5'd0, 8'h00, "r0_stopped");
    chk("r0_irq_off", irq, 0);

    // Two channels: ch0 RELOAD=3, ch1 RELOAD=7, SUMMARY progression.
    wr(5'd3, 8'h03);
    wr(5'd9, 8'h00); wr(5'd10, 8'h00); wr(5'd11, 8'h07);
    wr(5'd0, 8'h41);
    wr(5'd8, 8'h41);
    repeat (4) @(posedge clk);
    #1;
    rdchk(5'd7, 8'h01, "sum_01");
    repeat (3) @(posedge clk);
    #1;
    rdchk(5'd7, 8'h03, "sum_03");
    wr(5'd0, 8'h80);
    rdchk(5'd7, 8'h02, "sum_02");
    chk("sum_irq", irq, 1);
    rdchk(5'd0, 8'h00, "ind_ch0");
    rdchk(5'd8, 8'hC1, "ind_ch1");

    // Asynchronous reset mid-count with irq high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", irq, 0);
    chk("arst_do", DO, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdchk(5'd8,  8'h00, "post_ch1_ctrl");
    rdchk(5'd11, 8'h00, "post_ch1_rld");
    rdchk(5'd12, 8'h00, "post_ch1_cnt");
    rdchk(5'd13, 8'h00, "post_ch1_snap");
    rdchk(5'd7,  8'h00, "post_sum");
    rdchk(5'd0,  8'h00, "post_ch0_ctrl");
    rdchk(5'd3,  8'h00, "post_ch0_rld");
    repeat (20) @(posedge clk);
    #1;
    chk("post_irq", irq, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
